// File: rtl/multicycle_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_alu_pkg
//  Brief    : Shared op encodings, FSM state type and counter sizing for the
//             multicycle ALU.
//  Revision : 1.0  initial release
// ============================================================================
package multicycle_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width able to hold the iteration count for a given data width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEF_DATA_WIDTH = 32;
  localparam int CNT_W          = cnt_width(DEF_DATA_WIDTH);

endpackage : multicycle_alu_pkg
`default_nettype wire

// File: rtl/multicycle_alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_alu_iter
//  Brief    : Shared iterative magnitude engine: shift-add multiply and
//             restoring shift-subtract divide, one bit per cycle. The first
//             bit is processed on the start edge directly from the operands.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_alu_iter
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EARLY_TERM = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_is_mul,
  input  logic [DATA_WIDTH-1:0]     i_a_mag,
  input  logic [DATA_WIDTH-1:0]     i_b_mag,
  output logic                      o_done,
  output logic [2*DATA_WIDTH-1:0]   o_prod,
  output logic [DATA_WIDTH-1:0]     o_quot,
  output logic [DATA_WIDTH-1:0]     o_rem
);

  localparam int c_W     = DATA_WIDTH;
  localparam int c_CNT_W = cnt_width(DATA_WIDTH);

  logic                 r_busy;
  logic                 r_mul;
  logic [c_CNT_W-1:0]   r_cnt;
  // MUL: shifting multiplicand. DIV: divisor in the low half.
  logic [2*c_W-1:0]     r_sh;
  // MUL: product accumulator. DIV: partial remainder in the low half.
  logic [2*c_W-1:0]     r_acc;
  // MUL: remaining multiplier bits. DIV: dividend bits shifting out, quotient in.
  logic [c_W-1:0]       r_mq;

  logic                 w_mul_src;
  logic [2*c_W-1:0]     w_sh_src;
  logic [2*c_W-1:0]     w_acc_src;
  logic [c_W-1:0]       w_mq_src;
  logic [c_W:0]         w_rem_sh;
  logic [c_W-1:0]       w_rem_sub;
  logic                 w_ge;
  logic [2*c_W-1:0]     w_sh_nxt;
  logic [2*c_W-1:0]     w_acc_nxt;
  logic [c_W-1:0]       w_mq_nxt;
  logic                 w_early_hit;

  // On the start edge the step operates on freshly loaded operands.
  assign w_mul_src = i_start ? i_is_mul : r_mul;
  assign w_sh_src  = i_start ? {{c_W{1'b0}}, (i_is_mul ? i_a_mag : i_b_mag)} : r_sh;
  assign w_acc_src = i_start ? '0 : r_acc;
  assign w_mq_src  = i_start ? (i_is_mul ? i_b_mag : i_a_mag) : r_mq;

  assign w_rem_sh  = {w_acc_src[c_W-1:0], w_mq_src[c_W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, w_sh_src[c_W-1:0]});
  // Only used when w_ge, where the difference always fits in c_W bits.
  assign w_rem_sub = w_rem_sh[c_W-1:0] - w_sh_src[c_W-1:0];

  // One multiply or divide bit step.
  always_comb begin
    w_sh_nxt  = w_sh_src;
    w_acc_nxt = w_acc_src;
    w_mq_nxt  = w_mq_src;
    if (w_mul_src) begin
      w_acc_nxt = w_acc_src + (w_mq_src[0] ? w_sh_src : '0);
      w_sh_nxt  = w_sh_src << 1;
      w_mq_nxt  = w_mq_src >> 1;
    end else begin
      w_acc_nxt = {{c_W{1'b0}}, (w_ge ? w_rem_sub : w_rem_sh[c_W-1:0])};
      w_mq_nxt  = {w_mq_src[c_W-2:0], w_ge};
    end
  end

  if (EARLY_TERM != 0) begin : g_early
    assign w_early_hit = r_mul & (r_mq == '0);
  end else begin : g_no_early
    assign w_early_hit = 1'b0;
  end

  assign o_done = r_busy & ((r_cnt == '0) | w_early_hit);
  assign o_prod = r_acc;
  assign o_quot = r_mq;
  assign o_rem  = r_acc[c_W-1:0];

  // Iteration registers: load plus first step on start, then step until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_mul  <= 1'b0;
      r_cnt  <= '0;
      r_sh   <= '0;
      r_acc  <= '0;
      r_mq   <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_mul  <= i_is_mul;
      r_cnt  <= c_CNT_W'(c_W - 1);
      r_sh   <= w_sh_nxt;
      r_acc  <= w_acc_nxt;
      r_mq   <= w_mq_nxt;
    end else if (r_busy) begin
      if (o_done) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - c_CNT_W'(1);
        r_sh  <= w_sh_nxt;
        r_acc <= w_acc_nxt;
        r_mq  <= w_mq_nxt;
      end
    end
  end

endmodule : multicycle_alu_iter
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_alu
//  Brief    : Add/sub/mul/div ALU with signed/unsigned mode, remainder and
//             divide-by-zero flag, valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EARLY_TERM = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_q,
  output logic [DATA_WIDTH-1:0] o_r,
  output logic                  o_ovf,
  output logic                  o_zero,
  output logic                  o_dbz
);

  localparam int c_W = DATA_WIDTH;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_op;
  logic               r_signed;
  logic [c_W-1:0]     r_a;
  logic [c_W-1:0]     r_b;

  logic               w_accept;
  logic               w_iter_op;
  logic               w_iter_done;
  logic [c_W-1:0]     w_a_mag;
  logic [c_W-1:0]     w_b_mag;
  logic [2*c_W-1:0]   w_iter_prod;
  logic [c_W-1:0]     w_iter_quot;
  logic [c_W-1:0]     w_iter_rem;
  logic [c_W:0]       w_sum;
  logic [c_W:0]       w_dif;
  logic               w_neg_q;
  logic               w_neg_r;
  logic [2*c_W-1:0]   w_prod_fix;
  logic [c_W-1:0]     w_quot_fix;
  logic [c_W-1:0]     w_rem_fix;
  logic               w_load;
  logic [c_W-1:0]     w_q;
  logic [c_W-1:0]     w_r;
  logic               w_ovf;
  logic               w_dbz;

  assign w_accept  = i_valid & (r_state == ST_IDLE);
  assign w_iter_op = (i_op == OP_MUL) | (i_op == OP_DIV);
  assign w_a_mag   = (i_signed & i_a[c_W-1]) ? -i_a : i_a;
  assign w_b_mag   = (i_signed & i_b[c_W-1]) ? -i_b : i_b;

  multicycle_alu_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .EARLY_TERM (EARLY_TERM)
  ) u_iter (
    .clk      (i_clk),
    .rst      (i_rst),
    .i_start  (w_accept & w_iter_op),
    .i_is_mul (i_op == OP_MUL),
    .i_a_mag  (w_a_mag),
    .i_b_mag  (w_b_mag),
    .o_done   (w_iter_done),
    .o_prod   (w_iter_prod),
    .o_quot   (w_iter_quot),
    .o_rem    (w_iter_rem)
  );

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  // Quotient/product sign follows operand signs; remainder follows the dividend.
  assign w_neg_q    = r_signed & (r_a[c_W-1] ^ r_b[c_W-1]);
  assign w_neg_r    = r_signed & r_a[c_W-1];
  assign w_prod_fix = w_neg_q ? -w_iter_prod : w_iter_prod;
  assign w_quot_fix = w_neg_q ? -w_iter_quot : w_iter_quot;
  assign w_rem_fix  = w_neg_r ? -w_iter_rem  : w_iter_rem;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_state_nxt = w_iter_op ? ST_CALC : ST_DONE;
        end
      end
      ST_CALC: begin
        if (w_iter_done) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Result selection: ADD/SUB straight from the inputs at accept, MUL/DIV
  // from the engine on its final (sign-fix) cycle.
  always_comb begin
    w_load = 1'b0;
    w_q    = '0;
    w_r    = '0;
    w_ovf  = 1'b0;
    w_dbz  = 1'b0;
    if (w_accept && !w_iter_op) begin
      w_load = 1'b1;
      if (i_op == OP_ADD) begin
        w_q   = w_sum[c_W-1:0];
        w_ovf = i_signed ? ((i_a[c_W-1] == i_b[c_W-1]) && (w_sum[c_W-1] != i_a[c_W-1]))
                         : w_sum[c_W];
      end else begin
        w_q   = w_dif[c_W-1:0];
        w_ovf = i_signed ? ((i_a[c_W-1] != i_b[c_W-1]) && (w_dif[c_W-1] != i_a[c_W-1]))
                         : w_dif[c_W];
      end
    end else if ((r_state == ST_CALC) && w_iter_done) begin
      w_load = 1'b1;
      if (r_op == OP_MUL) begin
        w_q   = w_prod_fix[c_W-1:0];
        w_ovf = r_signed ? (w_prod_fix[2*c_W-1:c_W] != {c_W{w_prod_fix[c_W-1]}})
                         : (w_prod_fix[2*c_W-1:c_W] != '0);
      end else if (r_b == '0) begin
        w_q   = '1;
        w_r   = r_a;
        w_dbz = 1'b1;
      end else begin
        w_q   = w_quot_fix;
        w_r   = w_rem_fix;
        w_ovf = r_signed && (r_a == {1'b1, {(c_W-1){1'b0}}}) && (r_b == '1);
      end
    end
  end

  // Operand capture at accept; later input changes are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op     <= OP_ADD;
      r_signed <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (w_accept) begin
      r_op     <= i_op;
      r_signed <= i_signed;
      r_a      <= i_a;
      r_b      <= i_b;
    end
  end

  // Output registers, held until the next result is produced.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_q    <= '0;
      o_r    <= '0;
      o_ovf  <= 1'b0;
      o_zero <= 1'b0;
      o_dbz  <= 1'b0;
    end else if (w_load) begin
      o_q    <= w_q;
      o_r    <= w_r;
      o_ovf  <= w_ovf;
      o_zero <= (w_q == '0);
      o_dbz  <= w_dbz;
    end
  end

endmodule : multicycle_alu
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_alu
//  Brief    : Directed self-checking bench for multicycle_alu (32-bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_alu;

  localparam int W = 32;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [1:0]   i_op = 2'b00;
  logic         i_signed = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_q;
  logic [W-1:0] o_r;
  logic         o_ovf;
  logic         o_zero;
  logic         o_dbz;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_alu #(
    .DATA_WIDTH (W),
    .EARLY_TERM (0)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_signed (i_signed),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_q      (o_q),
    .o_r      (o_r),
    .o_ovf    (o_ovf),
    .o_zero   (o_zero),
    .o_dbz    (o_dbz)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one operation, check latency and results, optionally stall the
  // consumer for 'stall' cycles, then complete the result handshake.
  task automatic do_op(input string tag, input logic [1:0] op, input logic sg,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic eovf, input logic edbz, input int elat,
                       input int stall);
    int  lat;
    bit  got;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(o_ready), 64'(1));
    i_op = op; i_signed = sg; i_a = a; i_b = b; i_valid = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        i_valid = 1'b0;
        i_a = ~a; i_b = a ^ b; i_op = ~op; i_signed = ~sg;
      end
      got = o_valid;
    end
    if (!got) begin
      check({tag, "_timeout"}, 64'(0), 64'(1));
      return;
    end
    check({tag, "_lat"},  64'(lat),    64'(elat));
    check({tag, "_q"},    64'(o_q),    64'(eq));
    check({tag, "_r"},    64'(o_r),    64'(er));
    check({tag, "_ovf"},  64'(o_ovf),  64'(eovf));
    check({tag, "_zero"}, 64'(o_zero), 64'(eq == '0));
    check({tag, "_dbz"},  64'(o_dbz),  64'(edbz));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      i_valid = 1'b1; i_op = ADD; i_signed = 1'b0; i_a = 32'h1111; i_b = 32'h2222;
      @(posedge clk);
      #1;
      check({tag, "_stall_vld"}, 64'(o_valid), 64'(1));
      check({tag, "_stall_rdy"}, 64'(o_ready), 64'(0));
      check({tag, "_stall_q"},   64'(o_q),     64'(eq));
      check({tag, "_stall_ovf"}, 64'(o_ovf),   64'(eovf));
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check({tag, "_taken_vld"}, 64'(o_valid), 64'(0));
    check({tag, "_taken_rdy"}, 64'(o_ready), 64'(1));
  endtask

  initial begin
    int vld_seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(o_ready), 64'(1));
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_outs",  {o_q, o_r}, 64'(0));
    check("rst_flags", 64'({o_ovf, o_zero, o_dbz}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    //    tag             op   s   a              b              q              r              ovf dbz lat stall
    do_op("add_s_ovf",    ADD, 1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,         1, 0, 1,  0);
    do_op("add_u_wrap",   ADD, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,         1, 0, 1,  0);
    do_op("add_s_neg",    ADD, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0,         0, 0, 1,  0);
    do_op("sub_u_borrow", SUB, 0, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0,         1, 0, 1,  0);
    do_op("sub_s",        SUB, 1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0,         0, 0, 1,  0);
    do_op("sub_s_ovf",    SUB, 1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,         1, 0, 1,  0);
    do_op("mul_s",        MUL, 1, 32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFCF, 32'h0,         0, 0, 33, 0);
    do_op("mul_u_ovf",    MUL, 0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h0,         1, 0, 33, 0);
    do_op("mul_u_big",    MUL, 0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h0,         1, 0, 33, 0);
    do_op("mul_s_ovf",    MUL, 1, 32'h00010000, 32'h00008000, 32'h80000000, 32'h0,         1, 0, 33, 0);
    do_op("mul_s_min",    MUL, 1, 32'hFFFF0000, 32'h00008000, 32'h80000000, 32'h0,         0, 0, 33, 0);
    do_op("mul_s_zero",   MUL, 1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h0,         0, 0, 33, 0);
    do_op("div_s",        DIV, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 33, 0);
    do_op("div_s_negb",   DIV, 1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0, 0, 33, 0);
    do_op("div_u",        DIV, 0, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 0, 0, 33, 0);
    do_op("div_u_big",    DIV, 0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 0, 0, 33, 0);
    do_op("div_u_dbz",    DIV, 0, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 0, 1, 33, 0);
    do_op("div_s_dbz",    DIV, 1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 0, 1, 33, 0);
    do_op("div_s_minm1",  DIV, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 33, 0);
    do_op("bp_mul",       MUL, 0, 32'h00000003, 32'h00000005, 32'h0000000F, 32'h0,         0, 0, 33, 5);

    // Reset ten cycles into a divide: outputs clear at once, op never completes.
    @(negedge clk);
    i_op = DIV; i_signed = 1'b1; i_a = 32'h7FFFFFFF; i_b = 32'h00000003; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(o_ready), 64'(1));
    check("midrst_valid", 64'(o_valid), 64'(0));
    check("midrst_outs",  {o_q, o_r}, 64'(0));
    check("midrst_flags", 64'({o_ovf, o_zero, o_dbz}), 64'(0));
    #2;
    rst = 1'b0;
    vld_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (o_valid) vld_seen++;
    end
    check("midrst_no_result", 64'(vld_seen), 64'(0));
    do_op("add_after_rst", ADD, 0, 32'h00000002, 32'h00000001, 32'h00000003, 32'h0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_multicycle_alu
`default_nettype wire
